rr_mux_n: RTL and testbench

RR_MUX_N -- requirements
Module: rr_mux_n

---
 rtl/rr_mux_pkg.sv | 12 +
 rtl/rr_mux_arbiter_n.sv | 33 +++
 rtl/rr_mux_n.sv | 92 +++++++++
 tb/tb_rr_mux_n.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/rr_mux_pkg.sv
// rr_mux_pkg: shared mode encodings and lock-state type for the rr_mux_n slice.
package rr_mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    typedef enum logic {
        ARB,
        LOCKED
    } lock_state_t;

endpackage

// File: rtl/rr_mux_arbiter_n.sv
// rr_arbiter_n: round-robin grant searching upward from ptr+1; lock pins the grant to ptr.
module rr_arbiter_n #(
    parameter  int NCH = 8,
    localparam int SW  = $clog2(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [SW-1:0]  ptr,
    input  logic           lock,
    output logic [NCH-1:0] grant,
    output logic [SW-1:0]  idx,
    output logic           found
);

    logic [SW-1:0] c;

    // Scan from the farthest offset down so the nearest requester after ptr wins last.
    always_comb begin
        c     = '0;
        idx   = ptr;
        found = lock ? req[ptr] : 1'b0;
        if (!lock) begin
            for (int i = NCH; i >= 1; i--) begin
                c = ptr + SW'(i);
                if (req[c]) begin
                    idx   = c;
                    found = 1'b1;
                end
            end
        end
        grant = found ? (NCH'(1) << idx) : '0;
    end

endmodule

// File: rtl/rr_mux_n.sv
// rr_mux_n: N-channel fixed/round-robin mux with a one-word registered output stage.
// Define RR_MUX_LOCK_EN to add in_last and lock a round-robin grant until the last word.
module rr_mux_n
    import rr_mux_pkg::*;
#(
    parameter  int NCH = 8,
    parameter  int DW  = 8,
    localparam int SW  = $clog2(NCH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode,
    input  logic [SW-1:0]     sel,
    input  logic [NCH-1:0]    in_valid,
    input  logic [NCH*DW-1:0] in_data,
    output logic [NCH-1:0]    in_ready,
    output logic              out_valid,
    output logic [DW-1:0]     out_data,
    output logic [SW-1:0]     out_ch,
    input  logic              out_ready
`ifdef RR_MUX_LOCK_EN
    ,
    input  logic [NCH-1:0]    in_last
`endif
);

    logic           load;
    logic           lock;
    logic [SW-1:0]  ptr;
    logic [NCH-1:0] rr_grant;
    logic [SW-1:0]  rr_idx;
    logic           rr_found;
    logic           fix_ok;
    logic           g_ok;
    logic [SW-1:0]  g_idx;
    logic [NCH-1:0] g_vec;
    logic           xfer;

    rr_arbiter_n #(.NCH(NCH)) u_arb (
        .req   (in_valid),
        .ptr   (ptr),
        .lock  (lock),
        .grant (rr_grant),
        .idx   (rr_idx),
        .found (rr_found)
    );

    assign load     = !out_valid || out_ready;
    assign fix_ok   = in_valid[sel];
    assign g_ok     = (mode == MODE_FIXED) ? fix_ok : rr_found;
    assign g_idx    = (mode == MODE_FIXED) ? sel : rr_idx;
    assign g_vec    = (mode == MODE_FIXED) ? (fix_ok ? (NCH'(1) << sel) : '0) : rr_grant;
    // rst_n gates the handshake so nothing is accepted while reset is held.
    assign xfer     = g_ok && load && rst_n;
    assign in_ready = xfer ? g_vec : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= SW'(NCH - 1);
        end else if (load) begin
            out_valid <= xfer;
            if (xfer) begin
                out_data <= in_data[g_idx*DW +: DW];
                out_ch   <= g_idx;
                if (mode == MODE_RR) ptr <= g_idx;
            end
        end
    end

`ifdef RR_MUX_LOCK_EN
    lock_state_t state;

    // A non-last RR word locks onto its channel; ptr already holds that channel while locked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARB;
        end else if (mode == MODE_FIXED) begin
            state <= ARB;
        end else if (xfer) begin
            state <= in_last[g_idx] ? ARB : LOCKED;
        end
    end

    assign lock = (state == LOCKED);
`else
    assign lock = 1'b0;
`endif

endmodule

// File: tb/tb_rr_mux_n.sv
// tb_rr_mux_n: directed table, hand-written corner sequences and a randomized model check for rr_mux_n.
module tb_rr_mux_n;

    localparam int NCH = 8;
    localparam int DW  = 8;
    localparam int SW  = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              mode = 1'b0;
    logic [SW-1:0]     sel = '0;
    logic [NCH-1:0]    in_valid = '0;
    logic [NCH*DW-1:0] in_data = '0;
    logic [NCH-1:0]    in_ready;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic [SW-1:0]     out_ch;
    logic              out_ready = 1'b0;
`ifdef RR_MUX_LOCK_EN
    logic [NCH-1:0]    in_last = '1;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rr_mux_n #(.NCH(NCH), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_ready (out_ready)
`ifdef RR_MUX_LOCK_EN
        ,
        .in_last   (in_last)
`endif
    );

    typedef struct {
        logic           mode;
        logic [SW-1:0]  sel;
        logic [NCH-1:0] valid;
        logic           ordy;
        logic [NCH-1:0] exp_rdy;
        logic           exp_ov;
        logic [SW-1:0]  exp_ch;
        logic           chk_ch;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pattern();
        for (int k = 0; k < NCH; k++) in_data[k*DW +: DW] = 8'hA0 | 8'(k);
    endtask

    // Inputs are already applied; check in_ready, take one edge, then check the output register.
    task automatic cyc(input string nm, input logic [NCH-1:0] exp_rdy, input logic exp_ov,
                       input logic [SW-1:0] exp_ch, input logic chk_ch);
        #1;
        chk({nm, "_in_ready"}, 64'(in_ready), 64'(exp_rdy));
        tick();
        chk({nm, "_out_valid"}, 64'(out_valid), 64'(exp_ov));
        if (chk_ch) begin
            chk({nm, "_out_ch"}, 64'(out_ch), 64'(exp_ch));
            chk({nm, "_out_data"}, 64'(out_data), 64'(8'hA0 | 8'(exp_ch)));
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = '1;
        out_ready = 1'b1;
        set_pattern();
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_ch", 64'(out_ch), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        tick();
        tick();
        rst_n    = 1'b1;
        in_valid = '0;
`ifdef RR_MUX_LOCK_EN
        in_last  = '1;
`endif
    endtask

    task automatic rand_phase(input int n);
        int m_ptr, m_ov, m_ch, g, c;
        logic [DW-1:0] m_data;
        logic [NCH-1:0] exp_rdy;
        logic m_lock, load, m_mode;
        logic [NCH-1:0] v;
        logic [NCH*DW-1:0] d;
        do_reset();
        m_ptr = NCH - 1; m_ov = 0; m_ch = 0; m_data = '0; m_lock = 1'b0;
        for (int t = 0; t < n; t++) begin
            mode      = ($urandom_range(0, 3) != 0);
            sel       = SW'($urandom_range(0, NCH - 1));
            in_valid  = NCH'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            for (int k = 0; k < NCH; k++) in_data[k*DW +: DW] = DW'($urandom);
`ifdef RR_MUX_LOCK_EN
            in_last   = NCH'($urandom);
`endif
            #1;
            g = -1;
            if (!mode) g = in_valid[sel] ? int'(sel) : -1;
            else if (m_lock) g = in_valid[m_ptr] ? m_ptr : -1;
            else
                for (int k = 1; k <= NCH; k++) begin
                    c = (m_ptr + k) % NCH;
                    if (g < 0 && in_valid[c]) g = c;
                end
            load    = (m_ov == 0) || out_ready;
            exp_rdy = (g >= 0 && load) ? NCH'(1 << g) : '0;
            chk("rand_in_ready", 64'(in_ready), 64'(exp_rdy));
            v = in_valid; d = in_data; m_mode = mode;
            if (load) begin
                m_ov = (g >= 0) ? 1 : 0;
                if (g >= 0) begin
                    m_data = d[g*DW +: DW];
                    m_ch   = g;
                    if (m_mode) m_ptr = g;
                end
            end
`ifdef RR_MUX_LOCK_EN
            if (!m_mode) m_lock = 1'b0;
            else if (g >= 0 && load) m_lock = !in_last[g];
`endif
            tick();
            chk("rand_out_valid", 64'(out_valid), 64'(m_ov));
            if (m_ov != 0) begin
                chk("rand_out_data", 64'(out_data), 64'(m_data));
                chk("rand_out_ch", 64'(out_ch), 64'(m_ch));
            end
            if (v == '0 && g >= 0) chk("rand_grant_without_valid", 64'(g), 64'(-1));
        end
    endtask

    initial begin
        tbl.push_back('{1'b0, 3'd5, 8'h20, 1'b1, 8'h20, 1'b1, 3'd5, 1'b1});
        for (int k = 0; k <= NCH; k++)
            tbl.push_back('{1'b1, 3'd0, 8'hFF, 1'b1, NCH'(1 << (k % NCH)), 1'b1, SW'(k % NCH), 1'b1});
        tbl.push_back('{1'b0, 3'd2, 8'hFB, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0});
        tbl.push_back('{1'b0, 3'd2, 8'hFB, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0});

        do_reset();
        foreach (tbl[i]) begin
            mode      = tbl[i].mode;
            sel       = tbl[i].sel;
            in_valid  = tbl[i].valid;
            out_ready = tbl[i].ordy;
            cyc($sformatf("tbl%0d", i), tbl[i].exp_rdy, tbl[i].exp_ov, tbl[i].exp_ch, tbl[i].chk_ch);
        end

        // Stall with ch0 held while ch4 waits, then release.
        do_reset();
        mode = 1'b1; in_valid = 8'h11; out_ready = 1'b0;
        cyc("stall_first", 8'h01, 1'b1, 3'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            sel  = SW'(i + 3);
            mode = (i != 1);
            cyc("stall_hold", 8'h00, 1'b1, 3'd0, 1'b1);
        end
        mode = 1'b1; out_ready = 1'b1;
        cyc("stall_release", 8'h10, 1'b1, 3'd4, 1'b1);

        // Asynchronous reset mid-cycle while a word is pending.
        in_valid = '0; out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 64'(out_valid), 64'd0);
        chk("async_rst_out_ch", 64'(out_ch), 64'd0);
        chk("async_rst_out_data", 64'(out_data), 64'd0);
        chk("async_rst_in_ready", 64'(in_ready), 64'd0);
        #1 rst_n = 1'b1;
        tick();
        mode = 1'b1; in_valid = 8'hFF; out_ready = 1'b1;
        cyc("post_rst_rr", 8'h01, 1'b1, 3'd0, 1'b1);

`ifdef RR_MUX_LOCK_EN
        do_reset();
        mode = 1'b1; out_ready = 1'b1; in_last = 8'hFF;
        in_valid = 8'h04;
        cyc("lock_seed", 8'h04, 1'b1, 3'd2, 1'b1);
        in_valid = 8'h0A; in_last = 8'hF7;
        cyc("lock_w0", 8'h08, 1'b1, 3'd3, 1'b1);
        cyc("lock_w1", 8'h08, 1'b1, 3'd3, 1'b1);
        in_last = 8'hFF;
        cyc("lock_w2", 8'h08, 1'b1, 3'd3, 1'b1);
        cyc("lock_next", 8'h02, 1'b1, 3'd1, 1'b1);
`endif

        rand_phase(400);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
